// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_map_pkg
// Description : Address map, STATUS register bit layout and address-region
//               decode shared by mem_responder and its testbench.
//               Contents:
//                 c_*_addr     - byte addresses of the mapped regions
//                 c_status_*   - bit positions inside the STATUS word
//                 region_e     - decoded address region
//                 decode_region() - word address (Addr[31:2]) to region
// Revision    : 1.0 - initial release
// ============================================================================
package mem_map_pkg;

    // RAM window is 0x0000_0000..0x0000_00FF.
    localparam logic [31:0] c_ram_last_addr = 32'h0000_00FF;
    localparam logic [31:0] c_timer_addr    = 32'h0000_1000;
    localparam logic [31:0] c_txdata_addr   = 32'h0000_1004;
    localparam logic [31:0] c_status_addr   = 32'h0000_1008;

    // STATUS = {25'b0, count[3:0], overflow, empty, full}
    localparam int c_status_full_bit  = 0;
    localparam int c_status_empty_bit = 1;
    localparam int c_status_ovf_bit   = 2;
    localparam int c_status_count_lsb = 3;
    localparam int c_status_count_w   = 4;

    typedef enum logic [2:0] {
        REGION_RAM    = 3'd0,
        REGION_TIMER  = 3'd1,
        REGION_TXDATA = 3'd2,
        REGION_STATUS = 3'd3,
        REGION_NONE   = 3'd4
    } region_e;

    // The byte offset Addr[1:0] never takes part in decode, so callers hand
    // in the 30-bit word address only.
    function automatic region_e decode_region(input logic [29:0] word_addr);
        region_e r;
        r = REGION_NONE;
        if (word_addr <= c_ram_last_addr[31:2]) begin
            r = REGION_RAM;
        end else if (word_addr == c_timer_addr[31:2]) begin
            r = REGION_TIMER;
        end else if (word_addr == c_txdata_addr[31:2]) begin
            r = REGION_TXDATA;
        end else if (word_addr == c_status_addr[31:2]) begin
            r = REGION_STATUS;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Processor data-bus plus byte-stream output bundle.
//               MemWrite / Addr / WriteData - store strobe, address, data
//               ReadData                    - combinational load data
//               out_data / out_valid        - head byte of output FIFO
//               out_ready                   - downstream accepts head byte
//               Modport slave  : the memory responder.
//               Modport master : the processor core / testbench.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  MemWrite,
        input  Addr,
        input  WriteData,
        input  out_ready,
        output ReadData,
        output out_data,
        output out_valid
    );

    modport master (
        output MemWrite,
        output Addr,
        output WriteData,
        output out_ready,
        input  ReadData,
        input  out_data,
        input  out_valid
    );
endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous byte FIFO with first-word-fall-through output.
//               A push while full is accepted only when a pop happens on the
//               same edge; a pop while empty is ignored.
//               Ports: clk, rst (sync, active high), i_push, i_data[7:0],
//                      i_pop, o_data[7:0] (0 when empty), o_full, o_empty,
//                      o_count[3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4     // power of two, 2..8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_push,
    input  wire logic [7:0] i_data,
    input  wire logic       i_pop,
    output logic      [7:0] o_data,
    output logic            o_full,
    output logic            o_empty,
    output logic      [3:0] o_count
);

    localparam int             c_ptr_w      = $clog2(DEPTH);
    localparam logic [3:0]     c_full_count = 4'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [3:0]         r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == 4'd0);
    assign o_full    = (r_count == c_full_count);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    // A pop on the same edge frees the slot the push needs.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-mapped data responder for a single-cycle core:
//               data RAM, free-running TIMER, TXDATA byte FIFO and STATUS.
//               Loads are combinational; stores take effect on the rising
//               edge.
//               Ports: clk, reset (sync, active high),
//                      bus (mem_responder_if.slave): MemWrite, Addr,
//                      WriteData, ReadData, out_data, out_valid, out_ready
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int RAM_WORDS  = 64,  // power of two, max 64
    parameter int FIFO_DEPTH = 4    // power of two, 2..8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_responder_if.slave  bus
);

    localparam int c_ram_aw = $clog2(RAM_WORDS);

    logic [31:0]         r_ram [RAM_WORDS];
    logic [31:0]         r_timer;
    logic                r_overflow;

    region_e             w_region;
    logic [c_ram_aw-1:0] w_ram_idx;
    logic                w_ram_we;
    logic                w_timer_store;
    logic                w_tx_store;
    logic                w_status_store;
    logic                w_overflow_event;
    logic                w_full;
    logic                w_empty;
    logic [3:0]          w_count;
    logic [7:0]          w_fifo_data;
    logic [31:0]         w_status;
    logic                w_unused;

    // Byte offset is ignored everywhere.
    assign w_unused = ^bus.Addr[1:0];

    assign w_region       = decode_region(bus.Addr[31:2]);
    // Word index is taken modulo RAM_WORDS: upper index bits alias.
    assign w_ram_idx      = bus.Addr[2 +: c_ram_aw];
    assign w_ram_we       = bus.MemWrite && (w_region == REGION_RAM);
    assign w_timer_store  = bus.MemWrite && (w_region == REGION_TIMER);
    assign w_tx_store     = bus.MemWrite && (w_region == REGION_TXDATA);
    assign w_status_store = bus.MemWrite && (w_region == REGION_STATUS);

    // A byte is dropped only when the FIFO is full and nothing leaves on
    // the same edge (full implies non-empty, so out_ready alone decides).
    assign w_overflow_event = w_tx_store && w_full && !bus.out_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_byte_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_tx_store),
        .i_data  (bus.WriteData[7:0]),
        .i_pop   (bus.out_ready),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.out_data  = w_fifo_data;
    assign bus.out_valid = !w_empty;

    // RAM is deliberately outside reset: a store in a reset cycle lands.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 32'd0;
        end else if (w_timer_store) begin
            r_timer <= 32'd0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // Overflow set beats a clearing store to STATUS on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_overflow_event) begin
            r_overflow <= 1'b1;
        end else if (w_status_store) begin
            r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_status                                          = 32'd0;
        w_status[c_status_full_bit]                       = w_full;
        w_status[c_status_empty_bit]                      = w_empty;
        w_status[c_status_ovf_bit]                        = r_overflow;
        w_status[c_status_count_lsb +: c_status_count_w]  = w_count;
    end

    always_comb begin
        bus.ReadData = 32'd0;
        case (w_region)
            REGION_RAM:    bus.ReadData = r_ram[w_ram_idx];
            REGION_TIMER:  bus.ReadData = r_timer;
            REGION_STATUS: bus.ReadData = w_status;
            default:       bus.ReadData = 32'd0;
        endcase
    end

endmodule
`default_nettype wire
